irq_pending_latch: RTL and testbench
====================================

Name: irq_pending_latch

Overview:
- Upstream stage of the 16-to-4 priority encoder.
- Captures rising edges on 16 request lines into sticky pending bits and applies a software mask.
- Drives the encoder's 16-bit input vector and its enable.
- Clears a pending bit when the downstream consumer acknowledges the index it served; counts request edges lost because the bit was already pending.

Parameters:
- N_REQ, 16, number of request lines; equals encoder input width.
- IDX_W, 4, acknowledge index width; must equal log2(N_REQ).
- DROP_W, 8, width of the saturating dropped-event counter.
- MASK_RST, 16'hFFFF, reset value of the mask register (all requests enabled).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_in  in  N_REQ  level request lines; a 0->1 transition is one event.
- mask_wr  in  1  write strobe for the mask register.
- mask_wdata  in  N_REQ  new mask value; 1 = request enabled.
- ack_valid  in  1  consumer has served the index on ack_idx this cycle.
- ack_idx  in  IDX_W  index being acknowledged (the encoder's binary output).
- drop_clr  in  1  synchronous clear of drop_count.
- encoder_in  out  N_REQ  pending & mask; feeds encoder input.
- enable  out  1  OR-reduction of encoder_in; feeds encoder enable.
- pending  out  N_REQ  raw pending register, unmasked, for status readback.
- drop_count  out  DROP_W  saturating count of lost request edges.

Behaviour:
- Reset, asynchronous on rst_n low:
  - req_prev = 0, pending = 0, mask = MASK_RST, drop_count = 0.
  - Consequently encoder_in = 0 and enable = 0.
  - Reset asserted mid-operation discards all pending state immediately, without waiting for a clock edge.
- Edge detect:
  - req_prev[i] <= req_in[i] every clock.
  - rise[i] = req_in[i] & ~req_prev[i].
  - A line held high yields exactly one event.
  - A line already high when reset releases produces an event on the first clock after release, because req_prev is 0.
- Pending update, per bit, each clock:
  - set[i] = rise[i].
  - clr[i] = ack_valid & (ack_idx == i).
  - Next pending[i] = set[i] | (pending[i] & ~clr[i]).
  - When set and clear hit the same bit in the same cycle, set wins, so the new event is retained.
  - An ack for a bit that is not pending is a no-op.
  - An ack_idx value of N_REQ or above, possible only when N_REQ < 2^IDX_W, is a no-op.
- Mask:
  - On mask_wr, mask <= mask_wdata at the clock edge.
  - Masking never clears pending bits. A masked pending bit reappears on encoder_in as soon as it is unmasked.
- Outputs:
  - encoder_in = pending & mask and enable = |encoder_in.
  - Both are combinational from registers only; no combinational path from any input.
  - Latency: req_in rises before edge k with req_in low at edge k-1 → pending, encoder_in and enable updated after edge k (1 cycle).
  - Ack at edge k → bit cleared after edge k.
- drop_count:
  - Increments by the number of i where rise[i] & pending[i] & ~clr[i], i.e. an edge arriving on a bit still pending and not being acked.
  - Multiple simultaneous drops add their total in one cycle.
  - Saturates at 2^DROP_W-1; it never wraps.
  - drop_clr has priority over increment: the count becomes 0 and drops in that cycle are not counted.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: req_in passes through a 2-flop synchronizer (reset to 0) before edge detect. Event-to-encoder_in latency becomes 3 cycles. Request pulses must be at least 1 clk wide after synchronization to be captured.
- Undefined: no synchronizer; req_in is assumed synchronous to clk; latency is 1 cycle.

Test Plan:
- Reset with req_in=16'h0000, then pulse req_in=16'h0024 for 1 cycle → pending=encoder_in=16'h0024, enable=1 one cycle later; holds after req_in returns to 0.
- With pending=16'h0024, ack_valid=1, ack_idx=5 → pending=16'h0004. Then ack_idx=2 → pending=0 and enable=0. Then ack_idx=9 → no change.
- Write mask_wdata=16'hFFFB, then raise req_in[2] → pending=16'h0004, encoder_in=0, enable=0. Write mask 16'hFFFF → encoder_in=16'h0004, enable=1.
- Same cycle: req_in[7] rises and ack_valid=1 with ack_idx=7, bit 7 already pending → pending[7] stays 1, drop_count unchanged.
- Bit 3 pending, no ack; toggle req_in[3] 0→1 three times → drop_count=3. Continue to 300 drops → saturates at 255. Assert drop_clr → 0.
- Assert rst_n low asynchronously mid-test with pending=16'hFFFF → pending, encoder_in, enable and drop_count are 0 before the next clk edge. Repeat two event checks with IRQ_SYNC_EN defined → latency is 3 cycles.

Source files
------------

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: sticky rising-edge capture of N_REQ request lines with a
// software mask, feeding the 16-to-4 priority encoder. Pending bits clear on
// the consumer's acknowledge; edges lost on an already-pending bit are counted
// in a saturating counter.
// Optional build macro IRQ_SYNC_EN: inserts a 2-flop synchronizer on req_in
// ahead of edge detection, so event-to-encoder_in latency becomes 3 cycles
// instead of 1.
module irq_pending_latch #(
    parameter int              N_REQ    = 16,
    parameter int              IDX_W    = 4,
    parameter int              DROP_W   = 8,
    parameter logic [N_REQ-1:0] MASK_RST = {N_REQ{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_in,
    input  logic              mask_wr,
    input  logic [N_REQ-1:0]  mask_wdata,
    input  logic              ack_valid,
    input  logic [IDX_W-1:0]  ack_idx,
    input  logic              drop_clr,
    output logic [N_REQ-1:0]  encoder_in,
    output logic              enable,
    output logic [N_REQ-1:0]  pending,
    output logic [DROP_W-1:0] drop_count
);

    // Popcount of simultaneous drops, and a sum wide enough never to overflow
    // before the saturation compare.
    localparam int CNT_W = $clog2(N_REQ + 1);
    localparam int SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [N_REQ-1:0]  req_s;
    logic [N_REQ-1:0]  req_prev_q;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  mask_q, mask_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic [N_REQ-1:0]  rise;
    logic [N_REQ-1:0]  clr;
    logic [N_REQ-1:0]  drop_ev;
    logic [CNT_W-1:0]  n_drop;
    logic [SUM_W-1:0]  drop_sum;

`ifdef IRQ_SYNC_EN
    logic [N_REQ-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer bringing asynchronous request lines into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req_in;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_in;
`endif

    // Edge detect: req_prev starts at 0, so a line already high when reset
    // releases counts as a fresh event.
    assign rise = req_s & ~req_prev_q;

    // Next pending, mask and drop-count values.
    // NOTE: every signal driven here gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        clr     = '0;
        n_drop  = '0;
        mask_d  = mask_q;
        for (int i = 0; i < N_REQ; i++) begin
            // Out-of-range indices match no bit and are therefore a no-op.
            clr[i] = ack_valid && (ack_idx == IDX_W'(i));
        end
        // Set wins over clear so an event coinciding with its own ack is kept.
        pending_d = rise | (pending_q & ~clr);
        drop_ev   = rise & pending_q & ~clr;
        for (int i = 0; i < N_REQ; i++) begin
            n_drop = n_drop + CNT_W'(drop_ev[i]);
        end
        drop_sum = SUM_W'(drop_count_q) + SUM_W'(n_drop);
        if (drop_clr) begin
            drop_count_d = '0;
        end else if (drop_sum > SUM_W'(DROP_MAX)) begin
            drop_count_d = DROP_MAX;
        end else begin
            drop_count_d = drop_sum[DROP_W-1:0];
        end
        if (mask_wr) begin
            mask_d = mask_wdata;
        end
    end

    // State registers; asynchronous reset discards all pending state at once.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RST;
            drop_count_q <= '0;
        end else begin
            req_prev_q   <= req_s;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Outputs are driven from registers only; no input reaches them
    // combinationally.
    assign encoder_in = pending_q & mask_q;
    assign enable     = |encoder_in;
    assign pending    = pending_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed self-checking bench for irq_pending_latch. Expected values are
// hand-computed; LAT tracks the request-to-pending latency of the build.
module tb_irq_pending_latch;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_in;
    logic        mask_wr;
    logic [15:0] mask_wdata;
    logic        ack_valid;
    logic [3:0]  ack_idx;
    logic        drop_clr;
    logic [15:0] encoder_in;
    logic        enable;
    logic [15:0] pending;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    irq_pending_latch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .ack_valid  (ack_valid),
        .ack_idx    (ack_idx),
        .drop_clr   (drop_clr),
        .encoder_in (encoder_in),
        .enable     (enable),
        .pending    (pending),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the selected lines followed by one low cycle.
    task automatic pulse(input logic [15:0] m);
        req_in = m;
        tick();
        req_in = '0;
        tick();
    endtask

    // Let events still inside the synchronizer reach the pending register.
    task automatic flush();
        repeat (LAT) tick();
    endtask

    task automatic ack(input logic [3:0] idx);
        ack_valid = 1'b1;
        ack_idx   = idx;
        tick();
        ack_valid = 1'b0;
    endtask

    task automatic write_mask(input logic [15:0] m);
        mask_wr    = 1'b1;
        mask_wdata = m;
        tick();
        mask_wr    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_in = '0; mask_wr = 1'b0; mask_wdata = '0;
        ack_valid = 1'b0; ack_idx = '0; drop_clr = 1'b0;
        #12;
        check("rst_pending", pending, 0);
        check("rst_enc", encoder_in, 0);
        check("rst_enable", enable, 0);
        check("rst_drop", drop_count, 0);
        rst_n = 1'b1;
        tick();

        // Single-cycle pulse on bits 2 and 5.
        req_in = 16'h0024;
        check("pre_edge_enable", enable, 0);
        tick();
        req_in = '0;
        for (int i = 0; i < LAT - 1; i++) begin
            check("lat_early_enable", enable, 0);
            tick();
        end
        check("pulse_pending", pending, 16'h0024);
        check("pulse_enc", encoder_in, 16'h0024);
        check("pulse_enable", enable, 1);
        tick(); tick();
        check("hold_pending", pending, 16'h0024);

        // Acknowledge clears one bit at a time.
        ack(4'd5);
        check("ack5_pending", pending, 16'h0004);
        ack(4'd2);
        check("ack2_pending", pending, 0);
        check("ack2_enable", enable, 0);
        ack(4'd9);
        check("ack9_empty", pending, 0);

        // Masking hides but keeps the pending bit.
        write_mask(16'hFFFB);
        pulse(16'h0004);
        flush();
        check("mask_pending", pending, 16'h0004);
        check("mask_enc", encoder_in, 0);
        check("mask_enable", enable, 0);
        ack(4'd9);
        check("ack_nonpending", pending, 16'h0004);
        write_mask(16'hFFFF);
        check("unmask_enc", encoder_in, 16'h0004);
        check("unmask_enable", enable, 1);
        ack(4'd2);
        check("unmask_clear", pending, 0);

        // Rise and ack on already-pending bit 7 in the same cycle: set wins.
        pulse(16'h0080);
        flush();
        check("b7_pending", pending, 16'h0080);
        req_in = 16'h0080;
        repeat (LAT - 1) tick();
        ack(4'd7);
        req_in = '0;
        check("setwins_pending", pending, 16'h0080);
        check("setwins_drop", drop_count, 0);
        ack(4'd7);
        check("b7_cleared", pending, 0);

        // Lost edges on pending bit 3.
        pulse(16'h0008);
        repeat (3) pulse(16'h0008);
        flush();
        check("drop3_pending", pending, 16'h0008);
        check("drop3_count", drop_count, 3);
        repeat (251) pulse(16'h0008);
        flush();
        check("drop254", drop_count, 254);
        pulse(16'h0008);
        flush();
        check("drop255", drop_count, 255);
        repeat (46) pulse(16'h0008);
        flush();
        check("drop_sat", drop_count, 255);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        check("drop_clr", drop_count, 0);

        // drop_clr wins over a drop in the same cycle.
        req_in = 16'h0008;
        repeat (LAT - 1) tick();
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        req_in = '0;
        tick();
        check("clr_priority", drop_count, 0);

        // Simultaneous drops on bits 0, 1 and 3 add in one cycle.
        pulse(16'h0003);
        flush();
        check("multi_pre", pending, 16'h000B);
        pulse(16'h000B);
        flush();
        check("multi_drop", drop_count, 3);

        // Asynchronous reset mid-cycle; mask must also return to all-ones.
        write_mask(16'h0000);
        pulse(16'hFFFF);
        flush();
        check("full_pending", pending, 16'hFFFF);
        check("full_enc_masked", encoder_in, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pending", pending, 0);
        check("arst_enc", encoder_in, 0);
        check("arst_enable", enable, 0);
        check("arst_drop", drop_count, 0);

        // Line held high across reset release gives exactly one event.
        req_in = 16'h0001;
        #1;
        rst_n = 1'b1;
        tick();
        repeat (LAT - 1) tick();
        check("rel_pending", pending, 16'h0001);
        check("rel_enc_mask_rst", encoder_in, 16'h0001);
        ack(4'd0);
        repeat (4) tick();
        check("held_one_event", pending, 0);
        req_in = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
